// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus bundle: instruction-memory read handshake,
// redirect input and the decode-side dequeue port.
interface fetch_queue_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_read;
    logic [XLEN-1:0] imem_address;
    logic            imem_resp;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic            redirect_sel;
    logic [XLEN-1:0] redirect_target;
    logic            deq_valid;
    logic            deq_ready;
    logic [31:0]     deq_instr;
    logic [XLEN-1:0] deq_pc;
    logic            misalign_fault;

    // Fetch unit side
    modport master (
        output imem_read, imem_address, deq_valid, deq_instr, deq_pc, misalign_fault,
        input  imem_resp, imem_rdata, redirect_valid, redirect_sel, redirect_target, deq_ready
    );

    // Memory / pipeline side
    modport slave (
        input  imem_read, imem_address, deq_valid, deq_instr, deq_pc, misalign_fault,
        output imem_resp, imem_rdata, redirect_valid, redirect_sel, redirect_target, deq_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding
// imem read at a time, buffers {pc, instr} in a circular queue that feeds
// decode, and handles redirects (dropping any in-flight wrong-path word).
// Optional misaligned-redirect trap: define FETCH_MISALIGN_CHK_EN.
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0060),
    parameter int unsigned     FQ_DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    fetch_queue_unit_if.master bus
);
    localparam int unsigned      PTR_W   = $clog2(FQ_DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

`ifdef FETCH_MISALIGN_CHK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN, S_FAULT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;
`endif

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fq_entry_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   addr_q;
    logic              read_q;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q, count_d, cnt_req;
    logic              push, pop, flush;
    logic [XLEN-1:0]   redir_tgt;
    fq_entry_t         fq_mem [FQ_DEPTH];
`ifdef FETCH_MISALIGN_CHK_EN
    logic              fault_q, fault_d;
    logic              redir_bad;
`endif

    // Redirect target selection (jalr clears bit 0)
    assign redir_tgt = bus.redirect_sel ? (bus.redirect_target & ~XLEN'(1)) : bus.redirect_target;
`ifdef FETCH_MISALIGN_CHK_EN
    assign redir_bad = (redir_tgt[1:0] != 2'b00);
`endif

    // Occupancy after this cycle's response/pop while requesting
    assign pop     = (count_q != '0) && bus.deq_ready;
    assign cnt_req = count_q + CNT_W'(bus.imem_resp) - CNT_W'(pop);

    // Next-state, next-pc and queue control
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        fault_d = fault_q;
`endif
        case (state_q)
            S_IDLE:  state_d = (count_q < DEPTH_C) ? S_REQ : S_HOLD;
            S_REQ: begin
                if (bus.imem_resp) begin
                    push = 1'b1;
                    pc_d = pc_q + XLEN'(4);
                end
                state_d = (cnt_req < DEPTH_C) ? S_REQ : S_HOLD;
            end
            S_HOLD:  state_d = (count_q < DEPTH_C) ? S_REQ : S_HOLD;
            S_DRAIN: begin
                if (bus.imem_resp) begin
`ifdef FETCH_MISALIGN_CHK_EN
                    state_d = fault_q ? S_FAULT : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            default: ;
        endcase

        if (bus.redirect_valid) begin
            pc_d  = redir_tgt;
            flush = 1'b1;
            push  = 1'b0;
            if ((state_q == S_REQ) || (state_q == S_DRAIN)) begin
                state_d = bus.imem_resp ? S_REQ : S_DRAIN;
            end else begin
                state_d = S_REQ;
            end
`ifdef FETCH_MISALIGN_CHK_EN
            fault_d = redir_bad;
            if (redir_bad && (state_d != S_DRAIN)) begin
                state_d = S_FAULT;
            end
`endif
        end

        count_d = flush ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
    end

    // State, pc and registered imem request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            read_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            read_q  <= (state_d == S_REQ) || (state_d == S_DRAIN);
            if (state_d == S_REQ) begin
                addr_q <= pc_d;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // Sticky misalignment fault
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fault_q <= 1'b0;
        else      fault_q <= fault_d;
    end
    assign bus.misalign_fault = fault_q;
`else
    assign bus.misalign_fault = 1'b0;
`endif

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + PTR_W'(1);
                if (pop)  head_q <= head_q + PTR_W'(1);
            end
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (push) fq_mem[tail_q] <= {pc_q, bus.imem_rdata};
    end

    assign bus.imem_read    = read_q;
    assign bus.imem_address = addr_q;
    assign bus.deq_valid    = (count_q != '0);
    assign bus.deq_instr    = fq_mem[head_q].instr;
    assign bus.deq_pc       = fq_mem[head_q].pc;
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined RV32I core. Generalises the datapath's PC register and pcmux into one block.
- Owns the fetch PC and drives the instruction-memory read handshake.
- Buffers fetched words with their PCs in a FQ_DEPTH-entry queue that feeds decode.
- Accepts redirects (branch/jal as alu_out, jalr as alu_mod2) and flushes wrong-path words, including a response still in flight.

Parameters:
- XLEN, 32, width of PC and address.
- RESET_PC, 32'h0000_0060, fetch PC loaded on reset.
- FQ_DEPTH, 4, queue entries; power of 2, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_read  out  1  read request; held until imem_resp.
- imem_address  out  XLEN  fetch address; stable while imem_read=1.
- imem_resp  in  1  one-cycle response strobe.
- imem_rdata  in  32  instruction word; valid with imem_resp.
- redirect_valid  in  1  redirect PC this cycle.
- redirect_sel  in  1  0 = alu_out (target as-is), 1 = alu_mod2 (target & ~1).
- redirect_target  in  XLEN  new PC source.
- deq_valid  out  1  queue head valid.
- deq_ready  in  1  decode accepts head.
- deq_instr  out  32  head instruction.
- deq_pc  out  XLEN  head PC.
- misalign_fault  out  1  see Optional Feature.

Behaviour:
- Reset (rst=0, async):
  - pc = RESET_PC; queue empty; count = 0; state IDLE.
  - imem_read = 0; deq_valid = 0; misalign_fault = 0.
- States:
  - IDLE: next cycle goes to REQ if count < FQ_DEPTH, else HOLD.
  - REQ: imem_read = 1, imem_address = pc.
    - On imem_resp without redirect: push {pc, imem_rdata}; pc <= pc+4.
    - Then stay in REQ if count after the push/pop < FQ_DEPTH, else go to HOLD.
    - Back-to-back fetch therefore costs zero idle cycles.
  - HOLD: imem_read = 0; go to REQ in the cycle after count < FQ_DEPTH.
  - DRAIN: imem_read = 1 at the old address, held stable until imem_resp.
    - On that response the data is dropped and the state goes to REQ, fetching the new pc.
- Redirect (redirect_valid=1):
  - pc <= selected target; queue flushed (count = 0) in the same edge.
  - Redirect has priority over pop and push.
  - If the state is REQ without imem_resp this cycle, go to DRAIN.
  - If imem_resp arrives in the same cycle, drop the data and go to REQ at the target.
  - From HOLD or IDLE, go to REQ.
  - A redirect while in DRAIN updates pc and stays in DRAIN.
- Queue:
  - Circular buffer; head/tail pointers are clog2(FQ_DEPTH) bits and wrap naturally; count is clog2(FQ_DEPTH)+1 bits.
  - First-word fall-through: deq_valid = (count != 0); head fields are combinational.
  - Pop on deq_valid & deq_ready.
  - Push and pop in the same cycle leave count unchanged, including when full.
  - A new request is issued only when count < FQ_DEPTH. At most one request is outstanding, so overflow is impossible.
- Arithmetic: pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - A redirect whose selected target has bits [1:0] != 0 sets misalign_fault = 1, flushes the queue and enters state FAULT. A DRAIN still completes first.
  - FAULT: imem_read = 0; fault held until the next redirect with an aligned target, which clears it and resumes at REQ.
- Undefined:
  - misalign_fault is tied to 0; no FAULT state.
  - Target bits [1:0] are used as given.

Test Plan:
- Reset release, memory responds 1 cycle after each request, deq_ready=1 -> addresses 0x60, 0x64, 0x68 issued back-to-back; deq_pc sequence matches; deq_instr equals the memory words.
- deq_ready=0, FQ_DEPTH=4 -> exactly 4 responses accepted, then imem_read=0 in HOLD. Raising deq_ready for 1 cycle -> one pop, and the next request (0x70) issues the following cycle.
- Redirect to 0x200 while a request to 0x6C is outstanding -> imem_address stays 0x6C until resp; that data is not enqueued; next request is 0x200; queue empty.
- Redirect with redirect_sel=1, target 0x305, in the same cycle as imem_resp -> response dropped; next address 0x304.
- rst pulled low mid-REQ -> imem_read=0 and deq_valid=0 immediately; after release, first address is 0x60.
- With FETCH_MISALIGN_CHK_EN: redirect_sel=0, target 0x102 -> misalign_fault=1, no requests. Redirect to 0x100 -> fault clears; next address 0x100.
